// File: rtl/disp_pkg.sv
// Shared definitions for the display path: BCD digit type, limits and the
// anode "off" level used by the scanner and the decoder.
package disp_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Anodes are active-low: a high level switches a digit off.
    localparam logic AN_OFF = 1'b1;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input bcd_digit_t nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/disp_scan_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and raises tick during the last count.
// Used by the display scanner and reusable by other slow timing logic.
module tick_gen #(
    parameter int DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == CW'(DIV - 1));

    // Wrapping refresh counter; the wrap happens on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed 7-segment scanner: holds a packed BCD value, steps through its
// digits once per refresh tick and drives the decoder input and the
// active-low anode lines, with optional leading-zero blanking.
module disp_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 27000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic [DIGIT_W*N_DIGITS-1:0] bcd_i,
    input  logic                        blank_lz_i,
    output logic [DIGIT_W-1:0]          w_o,
    output logic [N_DIGITS-1:0]         an_o,
    output logic                        err_o
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                        tick;
    logic [IW-1:0]               idx_reg;
    logic [DIGIT_W*N_DIGITS-1:0] shadow_reg;
    bcd_digit_t                  w_reg;
    logic [N_DIGITS-1:0]         an_reg;
    logic                        err_reg;

    bcd_digit_t                  digit      [N_DIGITS];
    logic [N_DIGITS-1:0]         nib_ok;
    logic [N_DIGITS:0]           upper_zero;
    logic [N_DIGITS-1:0]         lz_vec;
    logic                        load_ok;
    logic                        blank_now;
    logic [N_DIGITS-1:0]         one_hot;
    logic [N_DIGITS-1:0]         an_next;

    tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // upper_zero[k] is set when shadow digits N_DIGITS-1 down to k are all zero;
    // the chain is seeded with 1 above the most significant digit.
    assign upper_zero[N_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digit[gi]      = shadow_reg[gi*DIGIT_W +: DIGIT_W];
            assign nib_ok[gi]     = is_bcd(bcd_i[gi*DIGIT_W +: DIGIT_W]);
            assign upper_zero[gi] = (digit[gi] == '0) && upper_zero[gi+1];
        end
    endgenerate

    assign lz_vec    = upper_zero[N_DIGITS-1:0];
    assign load_ok   = &nib_ok;
    // Digit 0 is never blanked so a zero value still shows "0".
    assign blank_now = blank_lz_i && (idx_reg != '0) && lz_vec[idx_reg];
    assign one_hot   = N_DIGITS'(1) << idx_reg;
    assign an_next   = blank_now ? {N_DIGITS{AN_OFF}} : ~one_hot;

    // Scan index, shadow capture and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg    <= '0;
            shadow_reg <= '0;
            w_reg      <= '0;
            an_reg     <= {N_DIGITS{AN_OFF}};
            err_reg    <= 1'b0;
        end else begin
            if (tick) begin
                idx_reg <= (idx_reg == IW'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
            if (load_i && load_ok) begin
                shadow_reg <= bcd_i;
            end
            // Outputs follow the index and shadow as they stood before this edge.
            w_reg   <= digit[idx_reg];
            an_reg  <= an_next;
            err_reg <= load_i && !load_ok;
        end
    end

    assign w_o   = w_reg;
    assign an_o  = an_reg;
    assign err_o = err_reg;

endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Upstream stage of the 7-segment decoder `disp_dec`.
- Holds a multi-digit packed BCD value and time-multiplexes its digits onto the decoder's 4-bit input `w`.
- Drives the matching digit-enable (anode) lines, with optional leading-zero blanking and rejection of non-BCD loads.
- Sits between the arithmetic/result logic and `disp_dec` in the board top level.

Parameters:
- N_DIGITS, 4, number of display digits scanned (≥2).
- REFRESH_DIV, 27000, clock cycles each digit stays enabled (27 MHz → 1 kHz per digit); must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- load_i  in  1  one-cycle strobe; capture bcd_i.
- bcd_i  in  4*N_DIGITS  packed BCD value; digit 0 (least significant) in bits [3:0].
- blank_lz_i  in  1  1 = suppress leading zeros.
- w_o  out  4  BCD digit presented to disp_dec.w.
- an_o  out  N_DIGITS  digit enables, active-low, at most one bit low.
- err_o  out  1  one-cycle pulse: last load rejected.

Behaviour:
- Reset values (registered, visible the cycle after rst sampled high):
  - shadow register = 0; refresh counter = 0; digit index = 0.
  - w_o = 4'h0; an_o = all ones (all digits off); err_o = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (counter == REFRESH_DIV-1).
  - On tick, the digit index advances 0→1→…→N_DIGITS-1→0.
- Outputs:
  - All outputs are registered.
  - w_o and an_o reflect the current index and shadow with 1-cycle latency.
  - Digit k is enabled (an_o[k]=0) for exactly REFRESH_DIV consecutive cycles per scan period of N_DIGITS*REFRESH_DIV cycles.
- Load:
  - On load_i=1, every nibble of bcd_i is checked for ≤9.
  - All nibbles valid: shadow ← bcd_i at that edge; err_o stays 0.
  - Any nibble >9: shadow unchanged; err_o=1 in the next cycle only.
  - A load does not reset the refresh counter or the digit index. The new value appears on w_o one cycle after the capturing edge, in whatever digit slot is active.
- Leading-zero blanking:
  - When blank_lz_i=1, digit k (k>0) is blanked if shadow digits N_DIGITS-1 down to k are all zero.
  - Blanked means an_o = all ones for that slot's full duration; w_o still carries the digit value.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - blank_lz_i is sampled every cycle; a change takes effect with 1-cycle latency.
- Simultaneous events:
  - load_i coincident with tick: index advances AND shadow updates in the same edge. The next cycle shows the new value at the new index.
- Reset mid-scan: rst has priority over load_i and tick. The whole state returns to reset values; a load strobe in the same cycle is discarded and err_o is not raised.
- No combinational path from any input to any output.

Decomposition:
- Shared package disp_pkg:
  - BCD_MAX = 4'd9.
  - DIGIT_W = 4.
  - AN_OFF convention (all-ones = off).
  - Function is_bcd(nibble).
  - Typedef bcd_digit_t = logic [3:0].
- One natural sub-module: tick_gen, parameterised by REFRESH_DIV, containing the refresh counter and producing the one-cycle tick. It is reusable by the debouncer and other timing logic.
- Index/shadow/anode logic stays in disp_scan.
- Top level wires w_o directly to disp_dec.w.

Test Plan (bench uses N_DIGITS=4, REFRESH_DIV=4):
- Reset then idle → w_o=0, an_o=4'b1111 on the first post-reset cycle. Then an_o cycles 1110,1101,1011,0111, 4 cycles each, w_o=0 throughout.
- load_i with bcd_i=16'h1234, blank_lz_i=0 → while an_o=1110 w_o=4; 1101→3; 1011→2; 0111→1; pattern repeats every 16 cycles.
- load_i with bcd_i=16'h0045, blank_lz_i=1 → slots 0/1 show an_o=1110/w_o=5, 1101/w_o=4. Slots 2/3 show an_o=1111. Then load 16'h0000 → only slot 0 enabled, w_o=0.
- load_i with bcd_i=16'h12A4 after 16'h1234 held → err_o=1 for exactly one cycle; display continues showing 1234.
- load_i asserted on the tick cycle (counter=3) with 16'h9876 → next cycle shows the index advanced by one and w_o = new digit for that index. Then assert rst mid-slot together with load_i → an_o=1111, w_o=0, err_o=0, and the shadow stays cleared.
